// File: rtl/clock_disp_pkg.sv
// clock_disp_pkg: shared display geometry, scan states and segment constants.
package clock_disp_pkg;
  localparam int NUM_DIGITS = 6;
  localparam int SEG_W = 7;
  typedef enum logic [1:0] {IDLE, BLANK, DRIVE} scan_state_e;
  localparam logic [SEG_W-1:0] SEG_BLANK = '0;
  localparam logic [SEG_W-1:0] SEG_LIT = '1;
endpackage

// File: rtl/scan_tick_counter.sv
// scan_tick_counter: loadable down-counter that parks at zero; tc flags zero.
module scan_tick_counter #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         tc
);
  logic [W-1:0] cnt;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) cnt <= '0;
    else if (load) cnt <= load_val;
    else if (cnt != '0) cnt <= cnt - 1'b1;
  assign tc = cnt == '0;
endmodule

// File: rtl/seg_scan_driver.sv
// seg_scan_driver: time-multiplexes a 42-bit segment bus onto a 6-digit display.
// Optional PWM dimming via brightness port when SEG_SCAN_DIMMING_EN is defined.
module seg_scan_driver
  import clock_disp_pkg::*;
#(
  parameter int DIGIT_TICKS    = 1000,
  parameter int BLANK_TICKS    = 16,
  parameter bit SEG_ACTIVE_LOW = 1'b1,
  parameter bit AN_ACTIVE_LOW  = 1'b1
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        enable,
  input  logic [NUM_DIGITS*SEG_W-1:0] segment_in,
`ifdef SEG_SCAN_DIMMING_EN
  input  logic [3:0]                  brightness,
`endif
  output logic [SEG_W-1:0]            seg_out,
  output logic [NUM_DIGITS-1:0]       an_out,
  output logic                        frame_start
);
  localparam int MAXT = DIGIT_TICKS > BLANK_TICKS ? DIGIT_TICKS : BLANK_TICKS;
  localparam int CW = $clog2(MAXT + 1);
  localparam logic [CW-1:0] DRV_LD = CW'(DIGIT_TICKS - 1);
  localparam logic [CW-1:0] BLK_LD = CW'(BLANK_TICKS == 0 ? 0 : BLANK_TICKS - 1);
  localparam scan_state_e SLOT = BLANK_TICKS == 0 ? DRIVE : BLANK;
  localparam logic [CW-1:0] SLOT_LD = BLANK_TICKS == 0 ? DRV_LD : BLK_LD;
  localparam logic [SEG_W-1:0] SEG_INV = {SEG_W{SEG_ACTIVE_LOW}};
  localparam logic [NUM_DIGITS-1:0] AN_INV = {NUM_DIGITS{AN_ACTIVE_LOW}};
  scan_state_e state, state_d;
  logic [2:0] dig, dig_d;
  logic [NUM_DIGITS-1:0][SEG_W-1:0] shadow;
  logic load, snap, first, tc, last, pwm_on;
  logic [CW-1:0] ld_val;
  logic [SEG_W-1:0] seg_now;
  logic [NUM_DIGITS-1:0] an_now;
  scan_tick_counter #(.W(CW)) u_tick (
    .clk(clk), .rst_n(rst_n), .load(load), .load_val(ld_val), .tc(tc)
  );
  assign last = dig == 3'(NUM_DIGITS - 1);
  always_comb begin
    state_d = state;
    dig_d   = dig;
    load    = 1'b0;
    ld_val  = SLOT_LD;
    snap    = 1'b0;
    if (!enable) begin
      state_d = IDLE;
      dig_d   = '0;
    end else if (state == IDLE) begin
      state_d = SLOT;
      dig_d   = '0;
      load    = 1'b1;
      snap    = 1'b1;
    end else if (tc && state == BLANK) begin
      state_d = DRIVE;
      load    = 1'b1;
      ld_val  = DRV_LD;
    end else if (tc) begin
      state_d = SLOT;
      load    = 1'b1;
      dig_d   = last ? 3'd0 : dig + 3'd1;
      snap    = last;
    end
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state  <= IDLE;
      dig    <= '0;
      shadow <= '0;
      first  <= 1'b0;
    end else begin
      state <= state_d;
      dig   <= dig_d;
      first <= snap;
      if (snap) shadow <= segment_in;
    end
`ifdef SEG_SCAN_DIMMING_EN
  logic [3:0] pwm, bright;
  // brightness is latched on every DRIVE entry so a slot never changes duty midway
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      pwm    <= '0;
      bright <= '0;
    end else if (load && state_d == DRIVE) begin
      pwm    <= '0;
      bright <= brightness;
    end else if (state == DRIVE) pwm <= pwm + 4'd1;
  assign pwm_on = pwm < bright;
`else
  assign pwm_on = 1'b1;
`endif
  assign seg_now = state == DRIVE ? shadow[dig] : SEG_BLANK;
  assign an_now  = state == DRIVE && pwm_on ? NUM_DIGITS'(1) << dig : '0;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      seg_out     <= SEG_BLANK ^ SEG_INV;
      an_out      <= AN_INV;
      frame_start <= 1'b0;
    end else begin
      seg_out     <= seg_now ^ SEG_INV;
      an_out      <= an_now ^ AN_INV;
      frame_start <= first;
    end
endmodule

// File: tb/tb_seg_scan_driver.sv
// tb_seg_scan_driver: frame-position scoreboard for seg_scan_driver.
module tb_seg_scan_driver;
`ifdef SEG_SCAN_DIMMING_EN
  localparam int DT = 32;
  localparam bit DIM = 1'b1;
`else
  localparam int DT = 8;
  localparam bit DIM = 1'b0;
`endif
  localparam int BT = 2;
  localparam int SL = BT + DT;
  localparam int P = 6 * SL;
  typedef struct packed {logic [6:0] seg; logic [5:0] an; logic fs;} exp_t;
  localparam exp_t OFF = '{seg: 7'h7F, an: 6'h3F, fs: 1'b0};
  logic clk = 1'b0, rst_n = 1'b1, enable = 1'b0;
  logic [41:0] segment_in = '0;
  logic [3:0] brightness = 4'd15;
  logic [6:0] seg_out;
  logic [5:0] an_out;
  logic frame_start;
  int checks = 0, failures = 0;
  exp_t q[$];
  bit m_act = 1'b0;
  int m_pos = 0;
  logic [41:0] m_shadow = '0;
  logic [3:0] m_bright = '0;
  always #5 clk = ~clk;
  seg_scan_driver #(
    .DIGIT_TICKS(DT), .BLANK_TICKS(BT), .SEG_ACTIVE_LOW(1'b1), .AN_ACTIVE_LOW(1'b1)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .enable(enable),
    .segment_in(segment_in),
`ifdef SEG_SCAN_DIMMING_EN
    .brightness(brightness),
`endif
    .seg_out(seg_out),
    .an_out(an_out),
    .frame_start(frame_start)
  );
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL %s got=%0h want=%0h t=%0t", tag, got, want, $time);
    end
  endtask
  // expected outputs derived from position within the frame, not from a state machine
  function automatic exp_t model_out();
    exp_t e = OFF;
    int d, o;
    if (m_act) begin
      d = m_pos / SL;
      o = m_pos % SL;
      e.fs = m_pos == 0;
      if (o >= BT) begin
        e.seg = ~m_shadow[7*d +: 7];
        if (!DIM || ((o - BT) % 16) < int'(m_bright)) e.an = ~(6'h01 << d);
      end
    end
    return e;
  endfunction
  task automatic step();
    exp_t e;
    if (!rst_n) begin
      m_act = 1'b0;
      m_pos = 0;
      m_shadow = '0;
    end else if (!enable) begin
      m_act = 1'b0;
      m_pos = 0;
    end else begin
      m_pos = m_act ? (m_pos + 1) % P : 0;
      m_act = 1'b1;
      if (m_pos == 0) m_shadow = segment_in;
      if (m_pos % SL == BT) m_bright = brightness;
    end
    @(posedge clk);
    #1;
    if (q.size() == 0) begin
      failures++;
      $display("FAIL queue_underflow t=%0t", $time);
    end else begin
      e = q.pop_front();
      chk("seg", 32'(seg_out), 32'(e.seg));
      chk("an", 32'(an_out), 32'(e.an));
      chk("fs", 32'(frame_start), 32'(e.fs));
    end
    q.push_back(model_out());
  endtask
  task automatic advance_to(input int d, input int o);
    for (int i = 0; i < 2 * P && !(m_act && m_pos == d * SL + o); i++) step();
  endtask
  initial begin
    #1 rst_n = 1'b0;
    #1;
    chk("rst_seg", 32'(seg_out), 32'h7F);
    chk("rst_an", 32'(an_out), 32'h3F);
    chk("rst_fs", 32'(frame_start), 32'h0);
    q.push_back(OFF);
    repeat (3) step();
    rst_n = 1'b1;
    repeat (100) step();
    for (int k = 0; k < 6; k++) segment_in[7*k +: 7] = 7'(7'h01 << k);
    enable = 1'b1;
    repeat (2 * P + 5) step();
    advance_to(3, BT + 2);
    segment_in = '1;
    repeat (P + SL) step();
    advance_to(2, BT + 3);
    enable = 1'b0;
    repeat (5) step();
    enable = 1'b1;
    repeat (P + 5) step();
    advance_to(1, BT + 1);
    #2 rst_n = 1'b0;
    #1;
    chk("async_seg", 32'(seg_out), 32'h7F);
    chk("async_an", 32'(an_out), 32'h3F);
    chk("async_fs", 32'(frame_start), 32'h0);
    q.delete();
    q.push_back(OFF);
    step();
    rst_n = 1'b1;
    for (int k = 0; k < 6; k++) segment_in[7*k +: 7] = 7'(7'h40 >> k);
    repeat (P + 5) step();
    if (DIM) begin
      brightness = 4'd4;
      repeat (P + SL) step();
      brightness = 4'd0;
      repeat (P + SL) step();
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/seg_scan_driver.md
# seg_scan_driver

Consumes the 42-bit parallel seven-segment bus produced by the clock core (six digits × 7 segments) and time-multiplexes it onto a physical 6-digit common-anode/cathode display with one shared 7-line segment bus and six digit-select lines. It sits between the clock core's `segment` output and the board pins. It snapshots the bus once per frame so a digit never tears mid-scan, and it inserts a blanking gap between digits to suppress ghosting.

## Interface
Parameters:
- `DIGIT_TICKS`, 1000: clk cycles each digit is driven; must be ≥1.
- `BLANK_TICKS`, 16: clk cycles all digits are off between slots; 0 skips blanking.
- `SEG_ACTIVE_LOW`, 1: 1 means a lit segment drives `seg_out` bit to 0.
- `AN_ACTIVE_LOW`, 1: 1 means the selected digit drives its `an_out` bit to 0.

Ports:
- `clk`  in  1  single system clock.
- `rst_n`  in  1  asynchronous, active-low reset.
- `enable`  in  1  scan enable; low forces the display dark.
- `segment_in`  in  42  digit k occupies [7k+6:7k]; bit 0 = seg a … bit 6 = seg g; 1 = lit.
- `brightness`  in  4  PWM duty in sixteenths; present only with `SEG_SCAN_DIMMING_EN`.
- `seg_out`  out  7  physical segment lines, polarity per `SEG_ACTIVE_LOW`.
- `an_out`  out  6  digit selects, one-hot when active, polarity per `AN_ACTIVE_LOW`.
- `frame_start`  out  1  one-cycle pulse when a new snapshot is taken.

## Operation
- States: IDLE, BLANK, DRIVE. The digit index `dig` is 0..5.
- IDLE: all outputs off. When `enable` is sampled high, go to BLANK with `dig`=0.
- BLANK: lasts BLANK_TICKS cycles, then goes to DRIVE. If BLANK_TICKS=0, entry goes directly to DRIVE.
- DRIVE: lasts DIGIT_TICKS cycles.
  - `an_out` selects `dig`.
  - `seg_out` = shadow[7·dig+6:7·dig].
  - On exit, `dig` increments. After 5 it wraps to 0.
  - The next state is BLANK, or DRIVE when BLANK_TICKS=0.
- Snapshot: on every entry into the slot for `dig`=0 (BLANK or DRIVE), the shadow register loads `segment_in` and `frame_start` pulses. Changes to `segment_in` between snapshots are invisible.
- `enable` low in any state: the next state is IDLE, `dig`=0, and outputs go off the following cycle. The shadow keeps its value.
- "Off" means every `seg_out` bit is unlit and every `an_out` bit is deselected, after polarity is applied.

## Timing
- All outputs are registered. They reflect the state register with 1 cycle of latency.
- Reset values (polarity applied):
  - `seg_out` = all unlit (7'h7F when SEG_ACTIVE_LOW=1).
  - `an_out` = none selected (6'h3F when AN_ACTIVE_LOW=1).
  - `frame_start` = 0.
  - State = IDLE, `dig` = 0, shadow = 0, tick counter = 0.
- From `enable` rising (sampled at edge N):
  - `frame_start` is high in cycle N+1.
  - The first digit-0 drive appears at N+1+BLANK_TICKS.
- Frame period = 6·(BLANK_TICKS+DIGIT_TICKS) cycles exactly. `frame_start` pulses are spaced by this period while `enable` stays high.
- `an_out` is never selected during BLANK. No two `an_out` bits are ever simultaneously selected.
- The tick counter width is $clog2(max(DIGIT_TICKS, BLANK_TICKS)+1).
- Asserting `rst_n` mid-frame forces outputs off immediately, without waiting for a clock edge.

## Configuration
- `SEG_SCAN_DIMMING_EN` defined:
  - Adds the `brightness` port and a 4-bit PWM counter. The counter clears on DRIVE entry and increments each DRIVE cycle, modulo 16.
  - `an_out` is selected only while pwm_cnt < `brightness`. `seg_out` stays valid for the whole DRIVE.
  - `brightness`=0 keeps the display dark. `brightness`=15 gives 15/16 duty.
  - `brightness` is sampled on DRIVE entry and held for that slot.
- Not defined: no `brightness` port. `an_out` is selected for the full DRIVE duration.

## Structure
- Shared package `clock_disp_pkg` holds:
  - `NUM_DIGITS`=6 and `SEG_W`=7.
  - The scan-state enum {IDLE, BLANK, DRIVE}.
  - Segment constants for blank and lit patterns.
- One sub-module is natural: `scan_tick_counter`, a loadable down-counter with a terminal-count flag. It is shared by the BLANK and DRIVE timing.

## Test plan
Bench parameters throughout: DIGIT_TICKS=8, BLANK_TICKS=2, both polarities active-low.

1. Reset and idle:
   - Stimulus: `rst_n`=0, then release with `enable`=0 for 100 cycles.
   - Required: `seg_out`=7'h7F, `an_out`=6'h3F, `frame_start`=0 throughout.
2. Basic scan:
   - Stimulus: `segment_in` = digit k pattern 7'h01<<k; raise `enable`.
   - Required: `frame_start` pulses every 60 cycles.
   - Required: digit k is driven with `an_out`=~(6'h01<<k) and `seg_out`=~(7'h01<<k) for exactly 8 cycles.
   - Required: each drive slot is preceded by 2 all-off cycles.
3. Snapshot isolation:
   - Stimulus: change `segment_in` to all-ones while digit 3 is driven.
   - Required: digits 4 and 5 still show the old pattern.
   - Required: the new pattern appears only after the next `frame_start`.
4. Enable drop:
   - Stimulus: deassert `enable` mid-DRIVE of digit 2.
   - Required: outputs are off the next cycle.
   - Required: on re-enable, the scan restarts at digit 0 with `frame_start`.
5. Asynchronous reset mid-frame:
   - Stimulus: pulse `rst_n` low between clock edges.
   - Required: `seg_out`=7'h7F and `an_out`=6'h3F before the next edge.
6. Dimming (SEG_SCAN_DIMMING_EN, DIGIT_TICKS=32, `brightness`=4):
   - Required: per slot, `an_out` is selected for 8 of 32 cycles, in two runs of 4.
   - Required: `brightness`=0 keeps `an_out`=6'h3F.
